// File: rtl/window_5x5_gen.sv
// Streaming 5x5 window generator: four line buffers plus a 5x5 register array.
// Only interior windows (row>=4, col>=4) are flagged valid, one clock after the pixel.
module window_5x5_gen #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned IMG_W = 64,
    parameter int unsigned IMG_H = 64
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [DSIZE-1:0] in_data,
    output logic [DSIZE-1:0] od00,
    output logic [DSIZE-1:0] od01,
    output logic [DSIZE-1:0] od02,
    output logic [DSIZE-1:0] od03,
    output logic [DSIZE-1:0] od04,
    output logic [DSIZE-1:0] od05,
    output logic [DSIZE-1:0] od06,
    output logic [DSIZE-1:0] od07,
    output logic [DSIZE-1:0] od08,
    output logic [DSIZE-1:0] od09,
    output logic [DSIZE-1:0] od10,
    output logic [DSIZE-1:0] od11,
    output logic [DSIZE-1:0] od12,
    output logic [DSIZE-1:0] od13,
    output logic [DSIZE-1:0] od14,
    output logic [DSIZE-1:0] od15,
    output logic [DSIZE-1:0] od16,
    output logic [DSIZE-1:0] od17,
    output logic [DSIZE-1:0] od18,
    output logic [DSIZE-1:0] od19,
    output logic [DSIZE-1:0] od20,
    output logic [DSIZE-1:0] od21,
    output logic [DSIZE-1:0] od22,
    output logic [DSIZE-1:0] od23,
    output logic [DSIZE-1:0] od24,
    output logic             out_valid,
    output logic             out_last
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);
    localparam logic [CW-1:0] FIRST_WIN_COL = CW'(4);
    localparam logic [RW-1:0] FIRST_WIN_ROW = RW'(4);

    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic [DSIZE-1:0] lb  [4][IMG_W];  // lb[0] is the oldest line (row-4)
    logic [DSIZE-1:0] win [5][5];
    logic             accept;
    logic             at_interior;
    logic             at_frame_end;

    // A pixel arriving with rst is dropped, so nothing may update on it.
    assign accept       = in_valid && !rst;
    assign at_interior  = (row >= FIRST_WIN_ROW) && (col >= FIRST_WIN_COL);
    assign at_frame_end = (row == LAST_ROW) && (col == LAST_COL);

    always_ff @(posedge clock) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (in_valid) begin
            if (col == LAST_COL) begin
                col <= '0;
                row <= (row == LAST_ROW) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Line buffers carry no reset; their stale contents stay hidden by the interior gating.
    always_ff @(posedge clock) begin
        if (accept) begin
            for (int i = 0; i < 3; i++) begin
                lb[i][col] <= lb[i+1][col];
            end
            lb[3][col] <= in_data;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 5; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (in_valid) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 4; c++) begin
                    win[r][c] <= win[r][c+1];
                end
            end
            for (int r = 0; r < 4; r++) begin
                win[r][4] <= lb[r][col];
            end
            win[4][4] <= in_data;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= in_valid && at_interior;
            out_last  <= in_valid && at_frame_end;
        end
    end

    assign od00 = win[0][0];
    assign od01 = win[0][1];
    assign od02 = win[0][2];
    assign od03 = win[0][3];
    assign od04 = win[0][4];
    assign od05 = win[1][0];
    assign od06 = win[1][1];
    assign od07 = win[1][2];
    assign od08 = win[1][3];
    assign od09 = win[1][4];
    assign od10 = win[2][0];
    assign od11 = win[2][1];
    assign od12 = win[2][2];
    assign od13 = win[2][3];
    assign od14 = win[2][4];
    assign od15 = win[3][0];
    assign od16 = win[3][1];
    assign od17 = win[3][2];
    assign od18 = win[3][3];
    assign od19 = win[3][4];
    assign od20 = win[4][0];
    assign od21 = win[4][1];
    assign od22 = win[4][2];
    assign od23 = win[4][3];
    assign od24 = win[4][4];

endmodule
